// File: rtl/e_md_ctrl.sv
// e_md_ctrl: E-stage sequencer for the multiply/divide unit.
//   Accepts md-class ops from E, latches op/operands for the arithmetic core,
//   counts the fixed latency, then commits core HI/LO to the HI/LO block.
//   Also handles mthi/mtlo writes and the D-stage stall for md-class ops.
// Optional feature: define MD_STALL_CNT_EN to add the stall_cycles counter port.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Req               flush of the E-stage instruction this cycle
//   e_valid, e_op     E-stage instruction valid / md op code (0..8, others none)
//   rs_val, rt_val    forwarded operands
//   d_is_md           D-stage instruction is md-class
//   core_hi, core_lo  core results for the latched op/operands
//   core_op/a/b       latched op (0 mult,1 multu,2 div,3 divu) and operands
//   busy              unit is running an op
//   stall             D-stage stall (combinational)
//   hi_we/lo_we, hi_wdata/lo_wdata  HI/LO write port (combinational)
//   stall_cycles      (MD_STALL_CNT_EN only) count of stalled cycles
module e_md_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req,
   input  logic        e_valid,
   input  logic [3:0]  e_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   input  logic [31:0] core_hi,
   input  logic [31:0] core_lo,
   output logic [1:0]  core_op,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   output logic        busy,
   output logic        stall,
   output logic        hi_we,
   output logic        lo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
`ifdef MD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

   localparam logic [3:0] OP_MULT = 4'd1;
   localparam logic [3:0] OP_DIVU = 4'd4;
   localparam logic [3:0] OP_MTHI = 4'd7;
   localparam logic [3:0] OP_MTLO = 4'd8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        core_op_q, core_op_d;
   logic [31:0]       core_a_q, core_a_d;
   logic [31:0]       core_b_q, core_b_d;
   logic              issue;
   logic              start;
   logic              is_mult;

   // Issue/start qualification and next-state/HI-LO write decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      core_op_d = core_op_q;
      core_a_d  = core_a_q;
      core_b_d  = core_b_q;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_wdata  = '0;
      lo_wdata  = '0;

      issue   = e_valid & ~Req & (state_q == IDLE);
      start   = issue & (e_op >= OP_MULT) & (e_op <= OP_DIVU);
      is_mult = (e_op <= 4'd2);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               core_op_d = 2'(e_op - 4'd1);
               core_a_d  = rs_val;
               core_b_d  = rt_val;
               // cnt holds cycles remaining before the commit cycle
               cnt_d     = is_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1);
            end
            if (issue && (e_op == OP_MTHI)) begin
               hi_we    = 1'b1;
               hi_wdata = rs_val;
            end
            if (issue && (e_op == OP_MTLO)) begin
               lo_we    = 1'b1;
               lo_wdata = rs_val;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               // Commit cycle: core results written on the closing edge
               state_d  = IDLE;
               hi_we    = 1'b1;
               lo_we    = 1'b1;
               hi_wdata = core_hi;
               lo_wdata = core_lo;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-operand registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         core_op_q <= '0;
         core_a_q  <= '0;
         core_b_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         core_op_q <= core_op_d;
         core_a_q  <= core_a_d;
         core_b_q  <= core_b_d;
      end
   end

   assign core_op = core_op_q;
   assign core_a  = core_a_q;
   assign core_b  = core_b_q;
   assign busy    = (state_q == RUN);
   // Stall covers the accept cycle and every RUN cycle
   assign stall   = d_is_md & (busy | start);

`ifdef MD_STALL_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Free-running stalled-cycle counter, wraps naturally
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) stall_cycles_q <= '0;
      else     stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule
